// File: rtl/ai_status_compositor.sv
// Purpose: merges NUM_LAYERS RGB565 layers into one OLED pixel, with a frame-tick divider, thinking FSM and level blink.
// Latency: oled_data is registered, 1 clk after the layer_data/pixel_index it was built from.
// Backpressure: none; the pixel stream free-runs with the OLED driver's pixel_index.
// Ports: clk/reset_n (async, active-low); pixel_index (unused here, drives the layer ROMs);
//        level, thinking, layer_data, layer_en, prio_mode in; oled_data, anim_phase, frame_tick,
//        busy, level_flash out.
module ai_status_compositor #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int FRAME_RATE  = 16,
    parameter int NUM_LAYERS  = 3,
    parameter int LEVEL_W     = 2,
    parameter int ANIM_PHASES = 8,
    parameter int DONE_TICKS  = 4,
    parameter int FLASH_TICKS = 8,
    parameter int LEVEL_LAYER = 1,
    parameter int ANIM_LAYER  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [12:0]             pixel_index,
    input  logic [LEVEL_W-1:0]      level,
    input  logic                    thinking,
    input  logic [16*NUM_LAYERS-1:0] layer_data,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic                    prio_mode,
    output logic [15:0]             oled_data,
    output logic [7:0]              anim_phase,
    output logic                    frame_tick,
    output logic                    busy,
    output logic                    level_flash
);

    localparam int TICK_DIV = CLK_FREQ / FRAME_RATE;
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DCW      = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam int FCW      = $clog2(FLASH_TICKS + 1);

    localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
    localparam logic [7:0]     PHASE_LAST = 8'(ANIM_PHASES - 1);
    localparam logic [DCW-1:0] DONE_LAST  = DCW'(DONE_TICKS - 1);
    localparam logic [FCW-1:0] FLASH_INIT = FCW'(FLASH_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_THINK, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [TCW-1:0]   tick_cnt;
    logic [DCW-1:0]   done_cnt;
    logic [FCW-1:0]   flash_cnt;
    logic [LEVEL_W-1:0] level_q;
    logic             level_chg;
    logic             level_blank;
    logic [15:0]      eff_k;
    logic [15:0]      blend_or;
    logic [15:0]      blend_prio;

    // pixel_index only addresses the external layer ROMs
    logic unused_pixel_index;
    assign unused_pixel_index = ^pixel_index;

    // Tick divider: the tick is the last count before wrap, so the first
    // tick lands TICK_DIV clks after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign frame_tick = (tick_cnt == TICK_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: thinking edges take priority over the tick
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (thinking) state_nxt = S_THINK;
            S_THINK: if (!thinking) state_nxt = S_DONE;
            S_DONE: begin
                if (thinking) begin
                    state_nxt = S_THINK;
                end else if (frame_tick && done_cnt == DONE_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Animation phase and DONE hold counter. The phase only advances on a
    // tick when no state transition happens in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_phase <= 8'h00;
            done_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (thinking) anim_phase <= 8'h00;
                end
                S_THINK: begin
                    if (!thinking) begin
                        done_cnt <= '0;
                    end else if (frame_tick) begin
                        anim_phase <= (anim_phase == PHASE_LAST) ? 8'h00 : anim_phase + 8'h01;
                    end
                end
                S_DONE: begin
                    if (thinking) begin
                        anim_phase <= 8'h00;
                    end else if (frame_tick) begin
                        if (done_cnt == DONE_LAST) begin
                            anim_phase <= 8'h00;
                        end else begin
                            done_cnt <= done_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    anim_phase <= 8'h00;
                    done_cnt   <= '0;
                end
            endcase
        end
    end

    // Level blink: any level change (re)loads the full window
    assign level_chg = (level != level_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= '0;
            flash_cnt <= '0;
        end else begin
            level_q <= level;
            if (level_chg) begin
                flash_cnt <= FLASH_INIT;
            end else if (frame_tick && flash_cnt != '0) begin
                flash_cnt <= flash_cnt - 1'b1;
            end
        end
    end

    assign level_flash = (flash_cnt != '0);
    // Odd counts blank the level layer, giving a blink at half the tick rate
    assign level_blank = level_flash & flash_cnt[0];

    // Per-layer gating and both blend results; later layers overwrite
    // blend_prio, so the highest nonzero index wins.
    always_comb begin
        eff_k      = 16'h0000;
        blend_or   = 16'h0000;
        blend_prio = 16'h0000;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            eff_k = layer_en[k] ? layer_data[16*k +: 16] : 16'h0000;
            if (k == ANIM_LAYER && !busy) eff_k = 16'h0000;
            if (k == LEVEL_LAYER && level_blank) eff_k = 16'h0000;
            blend_or = blend_or | eff_k;
            if (eff_k != 16'h0000) blend_prio = eff_k;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oled_data <= 16'h0000;
        end else begin
            oled_data <= prio_mode ? blend_prio : blend_or;
        end
    end

endmodule
